// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Packs a valid/ready byte stream little-endian into DATA_W-bit
//            words and writes them sequentially into a RAM write port.
// Options  : MEM_LOADER_CHECKSUM_EN builds the running modulo-256 byte sum.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int LOAD_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    localparam int c_BPW    = ((DATA_W - 1) / 8) + 1;
    localparam int c_IDX_W  = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam int c_WORD_W = c_BPW * 8;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_BPW - 1);
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

    generate
        if (DATA_W <= 0) begin : g_bad_data_w
            $fatal(1, "mem_loader: DATA_W must be greater than 0");
        end
        if ((LOAD_WORDS < 1) || (LOAD_WORDS > 2**ADDR_W)) begin : g_bad_load_words
            $fatal(1, "mem_loader: LOAD_WORDS must be in 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_din;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_WORD_W-1:0]  r_word;
    logic [c_WORD_W-1:0]  w_word;
    logic                 w_accept;
    logic                 w_word_last;
    logic                 w_start_ok;
    logic                 w_last_addr;

    assign w_accept    = (r_state == S_FILL) && in_valid;
    assign w_word_last = (r_idx == c_LAST_IDX);
    assign w_last_addr = (r_addr == c_LAST_ADDR);
    assign w_start_ok  = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Word image with the incoming byte merged into the lane selected by r_idx.
    generate
        for (genvar b = 0; b < c_BPW; b++) begin : g_lane
            assign w_word[b*8 +: 8] = (r_idx == c_IDX_W'(b)) ? in_data : r_word[b*8 +: 8];
        end
        if (c_WORD_W > DATA_W) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = ^w_word[c_WORD_W-1:DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_FILL;
            end
            S_FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_word_last) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                w_state_next = w_last_addr ? S_DONE : S_FILL;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_FILL;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    // Abort suppresses the datapath too, so a partial word is never committed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_din  <= '0;
            r_idx  <= '0;
            r_word <= '0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr <= '0;
                        r_idx  <= '0;
                        r_word <= '0;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        r_word <= w_word;
                        if (w_word_last) begin
                            r_idx <= '0;
                            r_din <= w_word[DATA_W-1:0];
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_last_addr) r_addr <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign mem_din  = r_din;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= 8'h00;
        end else if (abort || w_start_ok) begin
            r_checksum <= 8'h00;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Directed bench for mem_loader across four parameter sets, with a
//            write scoreboard per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit c_CK = 1'b1;
`else
    localparam bit c_CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic [3:0] start_v, abort_v, valid_v;
    wire  [3:0] rdy_v, we_v, busy_v, done_v;
    wire  [3:0] a0, a1, a2;
    wire  [1:0] a3;
    wire  [7:0] d0, d3;
    wire  [15:0] d1;
    wire  [11:0] d2;
    wire  [7:0] k0, k1, k2, k3;

    logic [31:0] q0[$], q1[$], q2[$], q3[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_WORDS(4)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]),
        .in_data(in_data), .in_valid(valid_v[0]), .in_ready(rdy_v[0]), .mem_we(we_v[0]),
        .mem_addr(a0), .mem_din(d0), .busy(busy_v[0]), .done(done_v[0]), .checksum(k0));

    mem_loader #(.ADDR_W(4), .DATA_W(16), .LOAD_WORDS(2)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]),
        .in_data(in_data), .in_valid(valid_v[1]), .in_ready(rdy_v[1]), .mem_we(we_v[1]),
        .mem_addr(a1), .mem_din(d1), .busy(busy_v[1]), .done(done_v[1]), .checksum(k1));

    mem_loader #(.ADDR_W(4), .DATA_W(12), .LOAD_WORDS(1)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort_v[2]),
        .in_data(in_data), .in_valid(valid_v[2]), .in_ready(rdy_v[2]), .mem_we(we_v[2]),
        .mem_addr(a2), .mem_din(d2), .busy(busy_v[2]), .done(done_v[2]), .checksum(k2));

    mem_loader #(.ADDR_W(2), .DATA_W(8), .LOAD_WORDS(4)) u3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[3]), .abort(abort_v[3]),
        .in_data(in_data), .in_valid(valid_v[3]), .in_ready(rdy_v[3]), .mem_we(we_v[3]),
        .mem_addr(a3), .mem_din(d3), .busy(busy_v[3]), .done(done_v[3]), .checksum(k3));

    function automatic logic [7:0] ck(input logic [7:0] v);
        return v & {8{c_CK}};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_w(input int k, input logic [15:0] addr, input logic [15:0] data);
        case (k)
            0: q0.push_back({addr, data});
            1: q1.push_back({addr, data});
            2: q2.push_back({addr, data});
            default: q3.push_back({addr, data});
        endcase
    endtask

    task automatic mon(input int k, input logic [31:0] obs);
        logic [31:0] e;
        int sz;
        e = '0;
        case (k)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        check($sformatf("u%0d_write_expected", k), 64'(sz != 0), 64'd1);
        if (sz != 0) begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            check($sformatf("u%0d_write_addr_data", k), 64'(obs), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (we_v[0]) mon(0, {16'(a0), 16'(d0)});
        if (we_v[1]) mon(1, {16'(a1), d1});
        if (we_v[2]) mon(2, {16'(a2), 16'(d2)});
        if (we_v[3]) mon(3, {16'(a3), 16'(d3)});
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
    endtask

    task automatic pulse_abort(input int k);
        abort_v[k] = 1'b1;
        @(posedge clk); #1;
        abort_v[k] = 1'b0;
    endtask

    task automatic status(input int k, input string tag, input logic [2:0] exp);
        check($sformatf("u%0d_%s_busy_done_ready", k, tag), {busy_v[k], done_v[k], rdy_v[k]}, exp);
    endtask

    // Offers one byte; if it completes a word, checks the following WRITE cycle.
    task automatic send(input int k, input logic [7:0] b, input bit last);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        in_data    = b;
        valid_v[k] = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = rdy_v[k];
            @(posedge clk); #1;
            n++;
        end
        valid_v[k] = 1'b0;
        check($sformatf("u%0d_accept_%h", k, b), 64'(hs), 64'd1);
        if (last) begin
            @(negedge clk);
            check($sformatf("u%0d_we_after_%h", k, b), 64'(we_v[k]), 64'd1);
            check($sformatf("u%0d_ready_low_in_write_%h", k, b), 64'(rdy_v[k]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes3 [4];
        bytes3[0] = 8'h80; bytes3[1] = 8'h90; bytes3[2] = 8'h10; bytes3[3] = 8'h05;

        reset_n = 1'b0;
        in_data = 8'h00;
        start_v = '0;
        abort_v = '0;
        valid_v = '0;
        idle(2);
        check("reset_flags", {rdy_v, we_v, busy_v, done_v}, 64'd0);
        check("reset_addr_data", {a0, a1, a2, a3, d0, d1, d2, d3}, 64'd0);
        check("reset_checksum", {k0, k1, k2, k3}, 64'd0);
        reset_n = 1'b1;
        idle(1);

        // 8-bit words, full-rate stream
        pulse_start(0);
        status(0, "fill", 3'b101);
        expect_w(0, 0, 16'h11); send(0, 8'h11, 1'b1);
        expect_w(0, 1, 16'h22); send(0, 8'h22, 1'b1);
        expect_w(0, 2, 16'h33); send(0, 8'h33, 1'b1);
        expect_w(0, 3, 16'h44); send(0, 8'h44, 1'b1);
        idle(1);
        status(0, "done", 3'b010);
        check("u0_last_addr", 64'(a0), 64'd3);
        check("u0_checksum", 64'(k0), 64'(ck(8'hAA)));
        in_data    = 8'h99;
        valid_v[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("u0_ready_in_done", 64'(rdy_v[0]), 64'd0);
        end
        valid_v[0] = 1'b0;

        // 16-bit little-endian packing
        pulse_start(1);
        expect_w(1, 0, 16'h1234);
        send(1, 8'h34, 1'b0); send(1, 8'h12, 1'b1);
        expect_w(1, 1, 16'hABCD);
        send(1, 8'hCD, 1'b0); send(1, 8'hAB, 1'b1);
        idle(1);
        status(1, "done", 3'b010);
        check("u1_last_addr", 64'(a1), 64'd1);

        // Restart from DONE, abort a partial word, reload
        pulse_start(1);
        status(1, "restart", 3'b101);
        send(1, 8'h34, 1'b0);
        pulse_abort(1);
        status(1, "abort", 3'b000);
        check("u1_abort_we", 64'(we_v[1]), 64'd0);
        check("u1_abort_checksum", 64'(k1), 64'd0);
        idle(3);
        pulse_start(1);
        expect_w(1, 0, 16'h5678);
        send(1, 8'h78, 1'b0); send(1, 8'h56, 1'b1);
        pulse_abort(1);

        // 12-bit words, top nibble discarded
        pulse_start(2);
        expect_w(2, 0, 16'h0FFF);
        send(2, 8'hFF, 1'b0); send(2, 8'hFF, 1'b1);
        idle(1);
        status(2, "done", 3'b010);
        check("u2_last_addr", 64'(a2), 64'd0);

        // Full address space, random gaps, start while busy
        pulse_start(3);
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, 3));
            if (i == 1 || i == 3) pulse_start(3);
            expect_w(3, 16'(i), 16'(bytes3[i]));
            send(3, bytes3[i], 1'b1);
            if (i == 2) check("u3_checksum_partial", 64'(k3), 64'(ck(8'h20)));
        end
        idle(1);
        status(3, "done", 3'b010);
        check("u3_last_addr", 64'(a3), 64'd3);
        in_data    = 8'h5A;
        valid_v[3] = 1'b1;
        idle(3);
        valid_v[3] = 1'b0;
        status(3, "still_done", 3'b010);
        check("u3_no_wrap", 64'(a3), 64'd3);
        check("u3_checksum_held", 64'(k3), 64'(ck(8'h25)));

        // Reset asserted while a write is in flight
        pulse_start(0);
        expect_w(0, 0, 16'h77);
        send(0, 8'h77, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midload_reset_flags", {rdy_v, we_v, busy_v, done_v}, 64'd0);
        check("midload_reset_addr_data", {a0, a1, a2, a3, d0, d1, d2, d3}, 64'd0);
        check("midload_reset_checksum", {k0, k1, k2, k3}, 64'd0);
        idle(1);
        reset_n = 1'b1;
        idle(2);
        check("scoreboard_empty", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer-side counterpart to the file-initialised ROM path.
- Accepts a byte stream over a valid/ready handshake from the UART/boot channel.
- Packs the bytes little-endian (byte 0 lands in bits [7:0]) into DATA_W-bit words and writes them sequentially into a synchronous RAM through a single write port.
- Asserts busy for the whole load so the system can hold the Z80 in reset while memory is being filled.

Parameters:
- ADDR_W, 14, RAM address width; bits of mem_addr.
- DATA_W, 8, RAM word width; must be >0 (elaboration $fatal if 0).
- LOAD_WORDS, 2**ADDR_W, number of words written per load; legal range 1..2**ADDR_W (elaboration $fatal otherwise).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- abort  in  1  abandon the load; return to IDLE next cycle.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  RAM write strobe; one cycle per word.
- mem_addr  out  ADDR_W  RAM write address.
- mem_din  out  DATA_W  RAM write data.
- busy  out  1  high in FILL and WRITE.
- done  out  1  high in DONE.
- checksum  out  8  running byte sum (see Optional Feature).

Behaviour:
- Derived constant: BPW = ((DATA_W-1)/8)+1 bytes per word.
- Reset (async, reset_n=0): state IDLE. in_ready, mem_we, busy and done are 0. mem_addr, mem_din, byte index and checksum are 0.
- All outputs are registered or decoded from the registered state only. No combinational path from in_valid to in_ready.
- States:
  - IDLE: start=1 -> FILL; clears mem_addr, byte index, word register and checksum.
  - FILL: in_ready=1. A byte is accepted when in_valid && in_ready. The byte goes into word lane bp = byte index (bits bp*8 +: 8). Lane bits above DATA_W-1 are discarded. Byte index increments. When the accepted byte is index BPW-1 -> WRITE, and the byte index resets to 0.
  - WRITE (exactly one cycle): mem_we=1, in_ready=0; mem_addr and mem_din are stable. Next cycle: if mem_addr == LOAD_WORDS-1 -> DONE with mem_addr held. Otherwise mem_addr+1 -> FILL.
  - DONE: done=1, in_ready=0; bytes are ignored. start=1 -> FILL as from IDLE, and done drops the next cycle.
- Latency: the final byte of a word is accepted at edge N; mem_we is high during cycle N+1.
- Peak throughput: one word per BPW+1 cycles.
- mem_din holds the last written word until the next word completes. The RAM side must use only mem_we as a qualifier.
- mem_addr never wraps. When LOAD_WORDS = 2**ADDR_W, the last address is all-ones and the load terminates in DONE.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- abort in any state -> IDLE next edge with mem_we=0, busy=0, done=0. A partially packed word is discarded and never written.
- in_valid is low in FILL: the loader waits indefinitely with no timeout.
- Reset mid-load: immediate return to IDLE; mem_we drops asynchronously.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined: checksum is the modulo-256 sum of every byte accepted since the last start. It is updated on each handshake and held in DONE. It is cleared by start, abort or reset.
- Undefined: the checksum register is not built and checksum is driven constant 8'h00.

Test Plan:
- DATA_W=8, ADDR_W=4, LOAD_WORDS=4; start, then bytes 11,22,33,44 at full rate -> writes (0,11),(1,22),(2,33),(3,44). Each mem_we is one cycle after its handshake; in_ready is low during each WRITE. done=1 after the addr-3 write; busy=0.
- DATA_W=16, LOAD_WORDS=2; bytes 34,12,CD,AB -> writes (0,1234),(1,ABCD).
- DATA_W=12, LOAD_WORDS=1; bytes FF,FF -> a single write (0,FFF). Upper nibble discarded.
- DATA_W=16; after byte 34 assert abort -> no mem_we, IDLE. Then start and bytes 78,56 -> write (0,5678).
- ADDR_W=2, LOAD_WORDS=4 (full space); random in_valid gaps and start pulses while busy -> exactly 4 writes, addr 0..3, done set, no wrap to 0. Extra bytes in DONE see in_ready=0.
- With MEM_LOADER_CHECKSUM_EN: bytes 80,90,10 -> checksum 20. Without the macro, checksum reads 00. In either build, reset_n pulsed mid-load -> all outputs 0 immediately.
